multiport_regfile: RTL and testbench

Parametrised general-purpose register file for the CPU datapath, succeeding the fixed 2-read/1-write file. It provides a configurable number of read and write ports, same-cycle write-to-read bypass with defined write-port priority, and a per-register pending scoreboard. The issue stage uses the scoreboard to detect operands whose producer has not yet written back. It sits between decode (reads, allocation) and write-back (writes).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/multiport_regfile.sv | 112 +++++++++++
 tb/tb_multiport_regfile.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default geometry, operand types and
// the common enable/zero constants used by the datapath register files.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned REG_NUM_DEF = 32;

    typedef logic [$clog2(REG_NUM_DEF)-1:0] Reg_addr_t;
    typedef logic [DATA_W_DEF-1:0]          Reg_data_t;

    // Architectural register hardwired to zero when the zero-register option is on
    localparam int unsigned ZERO_REG = 0;

    localparam logic      ENABLE    = 1'b1;
    localparam logic      DISABLE   = 1'b0;
    localparam Reg_data_t ZERO_WORD = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard: a producer allocation marks a register
// busy until some write port writes it back.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned REG_NUM     = REG_NUM_DEF,
    parameter int unsigned READ_PORTS  = 2,
    parameter bit          ZERO_REG_EN = 1'b1,
    localparam int unsigned AW         = $clog2(REG_NUM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    input  logic [REG_NUM-1:0]       wr_hit,
    input  logic [READ_PORTS-1:0]    re,
    input  logic [READ_PORTS*AW-1:0] raddr,
    input  logic [READ_PORTS-1:0]    bypass_hit,
    output logic [READ_PORTS-1:0]    rbusy,
    output logic [REG_NUM-1:0]       pending_vec
);

    logic [REG_NUM-1:0] pending_q;
    logic [REG_NUM-1:0] pending_d;

    // Next pending state: a new allocation outranks a same-cycle write-back
    always_comb begin
        pending_d = pending_q;
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            if (alloc_en == ENABLE && alloc_addr == AW'(r) && !(ZERO_REG_EN && r == ZERO_REG)) begin
                pending_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                pending_d[r] = 1'b0;
            end
        end
    end

    // Pending register; reset flushes every outstanding producer
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Operand busy: pending and not rescued by a same-cycle bypass
    always_comb begin
        rbusy = '0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            rbusy[p] = re[p] & pending_q[raddr[p*AW +: AW]] & ~bypass_hit[p] & ~rst;
        end
    end

    assign pending_vec = pending_q;

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised multi-port register file with highest-index-wins write
// arbitration, same-cycle write-to-read bypass and a pending scoreboard.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned REG_NUM     = REG_NUM_DEF,
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned WRITE_PORTS = 2,
    parameter bit          ZERO_REG_EN = 1'b1,
    localparam int unsigned AW         = $clog2(REG_NUM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WRITE_PORTS-1:0]        we,
    input  logic [WRITE_PORTS*AW-1:0]     waddr,
    input  logic [WRITE_PORTS*DATA_W-1:0] wdata,
    input  logic [READ_PORTS-1:0]         re,
    input  logic [READ_PORTS*AW-1:0]      raddr,
    output logic [READ_PORTS*DATA_W-1:0]  rdata,
    output logic [READ_PORTS-1:0]         rbusy,
    input  logic                          alloc_en,
    input  logic [AW-1:0]                 alloc_addr,
    output logic [REG_NUM-1:0]            pending_vec
);

    logic [DATA_W-1:0]     regs_q [REG_NUM];
    logic [DATA_W-1:0]     regs_d [REG_NUM];
    logic [REG_NUM-1:0]    wr_hit;
    logic [READ_PORTS-1:0] bypass_hit;

    // Returns {hit, data} for the winning write port at target; later ports override earlier ones
    function automatic logic [DATA_W:0] arbitrate(
        input logic [WRITE_PORTS-1:0]        en,
        input logic [WRITE_PORTS*AW-1:0]     addrs,
        input logic [WRITE_PORTS*DATA_W-1:0] datas,
        input logic [AW-1:0]                 target
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
            if (en[w] == ENABLE && addrs[w*AW +: AW] == target) begin
                res = {1'b1, datas[w*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    // Per-register write decode; the zero register never accepts a write
    always_comb begin
        logic [DATA_W:0] arb;
        wr_hit = '0;
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            arb       = arbitrate(we, waddr, wdata, AW'(r));
            wr_hit[r] = arb[DATA_W] && !(ZERO_REG_EN && r == ZERO_REG);
            regs_d[r] = arb[DATA_W-1:0];
        end
    end

    // Storage array update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= regs_d[r];
                end
            end
        end
    end

    // Read ports: forced zero, then bypass from the winning writer, then the array
    always_comb begin
        logic [DATA_W:0] arb;
        logic [AW-1:0]   addr;
        rdata      = '0;
        bypass_hit = '0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            addr          = raddr[p*AW +: AW];
            arb           = arbitrate(we, waddr, wdata, addr);
            bypass_hit[p] = arb[DATA_W];
            if (rst || !re[p] || (ZERO_REG_EN && addr == AW'(ZERO_REG))) begin
                rdata[p*DATA_W +: DATA_W] = '0;
            end else if (arb[DATA_W]) begin
                rdata[p*DATA_W +: DATA_W] = arb[DATA_W-1:0];
            end else begin
                rdata[p*DATA_W +: DATA_W] = regs_q[addr];
            end
        end
    end

    regfile_scoreboard #(
        .REG_NUM     (REG_NUM),
        .READ_PORTS  (READ_PORTS),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .wr_hit      (wr_hit),
        .re          (re),
        .raddr       (raddr),
        .bypass_hit  (bypass_hit),
        .rbusy       (rbusy),
        .pending_vec (pending_vec)
    );

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: default 2R/2W instance plus a 4R/1W/64x64 instance,
// directed scenarios and randomized traffic checked against a behavioural model.
module tb_multiport_regfile;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: defaults (32 x 32, 2 read, 2 write)
    logic [1:0]  a_we = '0;
    logic [9:0]  a_waddr = '0;
    logic [63:0] a_wdata = '0;
    logic [1:0]  a_re = '0;
    logic [9:0]  a_raddr = '0;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic        a_alloc_en = 1'b0;
    logic [4:0]  a_alloc_addr = '0;
    logic [31:0] a_pend;

    // Instance B: 64 x 64, 4 read, 1 write
    logic         b_we = 1'b0;
    logic [5:0]   b_waddr = '0;
    logic [63:0]  b_wdata = '0;
    logic [3:0]   b_re = '0;
    logic [23:0]  b_raddr = '0;
    logic [255:0] b_rdata;
    logic [3:0]   b_rbusy;
    logic         b_alloc_en = 1'b0;
    logic [5:0]   b_alloc_addr = '0;
    logic [63:0]  b_pend;

    multiport_regfile dut_a (
        .clk(clk), .rst(rst), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .re(a_re), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
        .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr), .pending_vec(a_pend)
    );

    multiport_regfile #(
        .DATA_W(64), .REG_NUM(64), .READ_PORTS(4), .WRITE_PORTS(1), .ZERO_REG_EN(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .re(b_re), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
        .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr), .pending_vec(b_pend)
    );

    // Behavioural model: architectural contents and pending set per instance
    logic [31:0] ma_regs [32];
    bit          ma_pend [32];
    logic [63:0] mb_regs [64];
    bit          mb_pend [64];

    // Model update on each edge; writes applied in port order so the higher port lands last
    always @(posedge clk) begin
        if (rst) begin
            foreach (ma_regs[i]) begin ma_regs[i] = '0; ma_pend[i] = 0; end
            foreach (mb_regs[i]) begin mb_regs[i] = '0; mb_pend[i] = 0; end
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (a_we[w] && a_waddr[w*5 +: 5] != 0) begin
                    ma_regs[a_waddr[w*5 +: 5]] = a_wdata[w*32 +: 32];
                    ma_pend[a_waddr[w*5 +: 5]] = 0;
                end
            end
            if (a_alloc_en && a_alloc_addr != 0) ma_pend[a_alloc_addr] = 1;
            if (b_we && b_waddr != 0) begin
                mb_regs[b_waddr] = b_wdata;
                mb_pend[b_waddr] = 0;
            end
            if (b_alloc_en && b_alloc_addr != 0) mb_pend[b_alloc_addr] = 1;
        end
    end

    function automatic logic [31:0] exp_a_rdata(input int p);
        logic [4:0] addr = a_raddr[p*5 +: 5];
        if (rst || !a_re[p] || addr == 0) return '0;
        for (int w = 1; w >= 0; w--)
            if (a_we[w] && a_waddr[w*5 +: 5] == addr) return a_wdata[w*32 +: 32];
        return ma_regs[addr];
    endfunction

    function automatic logic exp_a_rbusy(input int p);
        logic [4:0] addr = a_raddr[p*5 +: 5];
        bit hit = 0;
        for (int w = 0; w < 2; w++)
            if (a_we[w] && a_waddr[w*5 +: 5] == addr) hit = 1;
        return a_re[p] && ma_pend[addr] && !hit && !rst;
    endfunction

    function automatic logic [63:0] exp_b_rdata(input int p);
        logic [5:0] addr = b_raddr[p*6 +: 6];
        if (rst || !b_re[p] || addr == 0) return '0;
        if (b_we && b_waddr == addr) return b_wdata;
        return mb_regs[addr];
    endfunction

    function automatic logic exp_b_rbusy(input int p);
        logic [5:0] addr = b_raddr[p*6 +: 6];
        return b_re[p] && mb_pend[addr] && !(b_we && b_waddr == addr) && !rst;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_we = '0; a_re = '0; a_alloc_en = 1'b0;
        b_we = 1'b0; b_re = '0; b_alloc_en = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            a_we = 2'($urandom); a_waddr = 10'($urandom); a_wdata = {$urandom, $urandom};
            a_alloc_en = 1'($urandom); a_alloc_addr = 5'($urandom);
            tick();
        end
        rst = 1'b1;
        a_re = 2'b11; a_raddr = {5'd5, 5'd5};
        a_we = 2'b01; a_waddr = {5'd0, 5'd5}; a_wdata = {32'h0, 32'hCAFE0005};
        a_alloc_en = 1'b1; a_alloc_addr = 5'd5;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (a_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", a_rdata); end
            checks++;
            if (a_rbusy !== 2'b00) begin errors++; $display("FAIL reset_rbusy got %b want 00", a_rbusy); end
            tick();
        end
        checks++;
        if (a_pend !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", a_pend); end
        rst = 1'b0;
        idle();
        a_re = 2'b01; a_raddr = {5'd0, 5'd5};
        @(negedge clk);
        checks++;
        if (a_rdata[31:0] !== 32'h0) begin errors++; $display("FAIL reset_r5 got %h want 0", a_rdata[31:0]); end
        checks++;
        if (a_pend !== 32'h0 || b_pend !== 64'h0) begin
            errors++; $display("FAIL reset_pending_after got %h/%h want 0", a_pend, b_pend);
        end
        tick();
        idle();
    endtask

    task automatic test_basic();
        a_we = 2'b01; a_waddr = {5'd0, 5'd3}; a_wdata = {32'h0, 32'hDEADBEEF};
        tick();
        idle();
        a_re = 2'b11; a_raddr = {5'd3, 5'd3};
        @(negedge clk);
        checks++;
        if (a_rdata !== {2{32'hDEADBEEF}}) begin errors++; $display("FAIL basic_r3 got %h want deadbeefdeadbeef", a_rdata); end
        tick();
        a_we = 2'b01; a_waddr = {5'd0, 5'd0}; a_wdata = {32'h0, 32'h1};
        a_re = 2'b01; a_raddr = {5'd0, 5'd0};
        @(negedge clk);
        checks++;
        if (a_rdata[31:0] !== 32'h0) begin errors++; $display("FAIL basic_r0_bypass got %h want 0", a_rdata[31:0]); end
        tick();
        a_we = '0;
        @(negedge clk);
        checks++;
        if (a_rdata[31:0] !== 32'h0) begin errors++; $display("FAIL basic_r0 got %h want 0", a_rdata[31:0]); end
        tick();
        idle();
    endtask

    task automatic test_conflict();
        a_we = 2'b11; a_waddr = {5'd7, 5'd7}; a_wdata = {32'h22, 32'h11};
        a_re = 2'b01; a_raddr = {5'd0, 5'd7};
        @(negedge clk);
        checks++;
        if (a_rdata[31:0] !== 32'h22) begin errors++; $display("FAIL conflict_bypass got %h want 22", a_rdata[31:0]); end
        tick();
        a_we = '0;
        @(negedge clk);
        checks++;
        if (a_rdata[31:0] !== 32'h22) begin errors++; $display("FAIL conflict_stored got %h want 22", a_rdata[31:0]); end
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        a_alloc_en = 1'b1; a_alloc_addr = 5'd9;
        tick();
        a_alloc_en = 1'b0;
        a_re = 2'b01; a_raddr = {5'd0, 5'd9};
        @(negedge clk);
        checks++;
        if (a_rbusy[0] !== 1'b1 || a_pend[9] !== 1'b1) begin
            errors++; $display("FAIL sb_busy got rbusy=%b pend=%b want 1/1", a_rbusy[0], a_pend[9]);
        end
        tick();
        a_we = 2'b10; a_waddr = {5'd9, 5'd0}; a_wdata = {32'h55, 32'h0};
        @(negedge clk);
        checks++;
        if (a_rbusy[0] !== 1'b0 || a_rdata[31:0] !== 32'h55) begin
            errors++; $display("FAIL sb_writeback got rbusy=%b data=%h want 0/55", a_rbusy[0], a_rdata[31:0]);
        end
        tick();
        a_we = '0;
        @(negedge clk);
        checks++;
        if (a_pend[9] !== 1'b0 || a_rbusy[0] !== 1'b0) begin
            errors++; $display("FAIL sb_cleared got pend=%b rbusy=%b want 0/0", a_pend[9], a_rbusy[0]);
        end
        tick();
        idle();
    endtask

    task automatic test_collision();
        a_alloc_en = 1'b1; a_alloc_addr = 5'd4;
        a_we = 2'b01; a_waddr = {5'd0, 5'd4}; a_wdata = {32'h0, 32'h44};
        tick();
        idle();
        a_re = 2'b10; a_raddr = {5'd4, 5'd0};
        @(negedge clk);
        checks++;
        if (a_pend[4] !== 1'b1 || a_rbusy[1] !== 1'b1 || a_rdata[63:32] !== 32'h44) begin
            errors++; $display("FAIL collide_r4 got pend=%b rbusy=%b data=%h want 1/1/44", a_pend[4], a_rbusy[1], a_rdata[63:32]);
        end
        a_alloc_en = 1'b1; a_alloc_addr = 5'd0;
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (a_pend[0] !== 1'b0) begin errors++; $display("FAIL collide_r0 got pend=%b want 0", a_pend[0]); end
        tick();
    endtask

    task automatic test_sweep();
        b_we = 1'b1; b_waddr = 6'd63; b_wdata = 64'h0123456789ABCDEF;
        tick();
        idle();
        b_re = 4'hF; b_raddr = {4{6'd63}};
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (b_rdata[p*64 +: 64] !== 64'h0123456789ABCDEF) begin
                errors++; $display("FAIL sweep_r63_p%0d got %h want 0123456789abcdef", p, b_rdata[p*64 +: 64]);
            end
        end
        tick();
        idle();
        b_alloc_en = 1'b1; b_alloc_addr = 6'd40;
        tick();
        b_alloc_en = 1'b0;
        b_re = 4'b1000; b_raddr = {6'd40, 18'd0};
        @(negedge clk);
        checks++;
        if (b_rbusy !== 4'b1000) begin errors++; $display("FAIL sweep_busy got %b want 1000", b_rbusy); end
        tick();
        b_we = 1'b1; b_waddr = 6'd40; b_wdata = 64'hFEDCBA9876543210;
        @(negedge clk);
        checks++;
        if (b_rbusy !== 4'b0000 || b_rdata[255:192] !== 64'hFEDCBA9876543210) begin
            errors++; $display("FAIL sweep_writeback got rbusy=%b data=%h want 0000/fedcba9876543210", b_rbusy, b_rdata[255:192]);
        end
        tick();
        b_we = 1'b1; b_waddr = 6'd0; b_wdata = 64'h1;
        b_alloc_en = 1'b1; b_alloc_addr = 6'd0;
        tick();
        idle();
        b_re = 4'b0001; b_raddr = '0;
        @(negedge clk);
        checks++;
        if (b_rdata[63:0] !== 64'h0 || b_pend !== 64'h0) begin
            errors++; $display("FAIL sweep_r0 got data=%h pend=%h want 0/0", b_rdata[63:0], b_pend);
        end
        tick();
        idle();
    endtask

    task automatic test_random_a(input int n);
        for (int i = 0; i < n; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            a_we = 2'($urandom);
            a_re = 2'($urandom);
            a_alloc_en = 1'($urandom);
            a_alloc_addr = 5'($urandom_range(0, 7));
            for (int k = 0; k < 2; k++) begin
                a_waddr[k*5 +: 5] = 5'($urandom_range(0, 7));
                a_raddr[k*5 +: 5] = 5'($urandom_range(0, 7));
                a_wdata[k*32 +: 32] = $urandom;
            end
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (a_rdata[p*32 +: 32] !== exp_a_rdata(p)) begin
                    errors++; $display("FAIL rand_a_rdata%0d cyc %0d got %h want %h", p, i, a_rdata[p*32 +: 32], exp_a_rdata(p));
                end
                checks++;
                if (a_rbusy[p] !== exp_a_rbusy(p)) begin
                    errors++; $display("FAIL rand_a_rbusy%0d cyc %0d got %b want %b", p, i, a_rbusy[p], exp_a_rbusy(p));
                end
            end
            for (int r = 0; r < 32; r++) begin
                checks++;
                if (a_pend[r] !== ma_pend[r]) begin
                    errors++; $display("FAIL rand_a_pend%0d cyc %0d got %b want %b", r, i, a_pend[r], ma_pend[r]);
                end
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_random_b(input int n);
        for (int i = 0; i < n; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            b_we = 1'($urandom);
            b_re = 4'($urandom);
            b_alloc_en = 1'($urandom);
            b_alloc_addr = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(58, 63));
            b_waddr = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(58, 63));
            b_wdata = {$urandom, $urandom};
            for (int k = 0; k < 4; k++)
                b_raddr[k*6 +: 6] = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(58, 63));
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (b_rdata[p*64 +: 64] !== exp_b_rdata(p)) begin
                    errors++; $display("FAIL rand_b_rdata%0d cyc %0d got %h want %h", p, i, b_rdata[p*64 +: 64], exp_b_rdata(p));
                end
                checks++;
                if (b_rbusy[p] !== exp_b_rbusy(p)) begin
                    errors++; $display("FAIL rand_b_rbusy%0d cyc %0d got %b want %b", p, i, b_rbusy[p], exp_b_rbusy(p));
                end
            end
            for (int r = 0; r < 64; r++) begin
                checks++;
                if (b_pend[r] !== mb_pend[r]) begin
                    errors++; $display("FAIL rand_b_pend%0d cyc %0d got %b want %b", r, i, b_pend[r], mb_pend[r]);
                end
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_conflict();
        test_scoreboard();
        test_collision();
        test_random_a(300);
        test_sweep();
        test_random_b(300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
